// File: rtl/booth_seq_mpy.sv
// Sequential radix-4 Booth multiplier for signed or unsigned WIDTH-bit operands.
// Each operation takes WIDTH/2+1 CALC cycles and uses a valid/ready handshake on both sides.
module booth_seq_mpy #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned QW    = WIDTH + 3;
  localparam int unsigned STEPS = WIDTH / 2 + 1;
  localparam int unsigned CW    = $clog2(STEPS);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic            live_q;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   m_q, m_d;
  logic [QW-1:0]   q_q, q_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   prod_q, prod_d;

  logic            a_ext, b_ext;
  logic [PW-1:0]   addend;
  logic [PW-1:0]   sum;

  assign a_ext = is_signed & a[WIDTH-1];
  assign b_ext = is_signed & b[WIDTH-1];

  assign in_ready  = (state_q == IDLE) && live_q;
  assign out_valid = (state_q == DONE);
  assign product   = prod_q;

  // M is kept pre-shifted by 4^i, so the window always reads q_q[2:0]; all
  // arithmetic is modulo 2^(2*WIDTH), which is exact for the true product.
  always_comb begin
    addend = '0;
    unique case (q_q[2:0])
      3'b001, 3'b010: addend = m_q;
      3'b011:         addend = m_q << 1;
      3'b100:         addend = '0 - (m_q << 1);
      3'b101, 3'b110: addend = '0 - m_q;
      default:        addend = '0;
    endcase
  end

  assign sum = acc_q + addend;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    m_d     = m_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_d = CALC;
          m_d     = {{(PW-WIDTH){a_ext}}, a};
          q_d     = {{2{b_ext}}, b, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      CALC: begin
        acc_d = sum;
        m_d   = m_q << 2;
        q_d   = q_q >> 2;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          prod_d  = sum;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      live_q  <= 1'b0;
      acc_q   <= '0;
      m_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      acc_q   <= acc_d;
      m_q     <= m_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

endmodule
